os_inst_sequencer: RTL and testbench



---
 rtl/os_inst_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_os_inst_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/os_inst_sequencer.sv
// Output-stationary instruction sequencer: per input channel fetches weights and activations,
// runs execute, then drains the array and writes the result rows to pmem. All outputs registered.
module os_inst_sequencer #(
  parameter int          LEN_KIJ   = 9,
  parameter int          LEN_NIJ   = 9,
  parameter int          LEN_ONIJ  = 8,
  parameter int          EXEC_CYC  = 21,
  parameter int          DRAIN_CYC = 10,
  parameter logic [10:0] A_BASE    = 11'h000,
  parameter logic [10:0] W_BASE    = 11'h400,
  parameter logic [10:0] P_BASE    = 11'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  num_ic,
  input  logic        ofifo_valid,
  output logic [35:0] inst,
  output logic        busy,
  output logic        done
);

  typedef struct packed {
    logic        output_en;
    logic        mode;
    logic        acc;
    logic        cen_pmem;
    logic        wen_pmem;
    logic [10:0] a_pmem;
    logic        cen_xmem;
    logic        wen_xmem;
    logic [10:0] a_xmem;
    logic        ofifo_rd;
    logic        ififo_wr;
    logic        ififo_rd;
    logic        l0_rd;
    logic        l0_wr;
    logic        execute;
    logic        load;
  } inst_t;

  typedef enum logic [2:0] {
    S_IDLE, S_WFETCH, S_AFETCH, S_EXEC, S_DRAIN, S_OUTWR, S_DONE
  } state_t;

  localparam inst_t IDLE_WORD = '{
    output_en: 1'b0, mode: 1'b1, acc: 1'b0, cen_pmem: 1'b1, wen_pmem: 1'b1,
    a_pmem: 11'd0, cen_xmem: 1'b1, wen_xmem: 1'b1, a_xmem: 11'd0,
    ofifo_rd: 1'b0, ififo_wr: 1'b0, ififo_rd: 1'b0, l0_rd: 1'b0,
    l0_wr: 1'b0, execute: 1'b0, load: 1'b0
  };

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [3:0] ic_q, ic_d, nic_q, nic_d;
  logic [3:0] r_q, r_d, w_q, w_d, r_base, w_base;
  logic       rd_q, rd_d, wr;
  inst_t      inst_q, inst_d;
  logic       busy_q, done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ic_d    = ic_q;
    nic_d   = nic_q;
    r_d     = r_q;
    w_d     = w_q;
    rd_d    = 1'b0;
    wr      = 1'b0;
    r_base  = '0;
    w_base  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_ic != 4'd0) begin
            state_d = S_WFETCH;
            nic_d   = num_ic;
            ic_d    = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WFETCH: begin
        if (cnt_q == 5'(LEN_KIJ)) begin
          state_d = S_AFETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_AFETCH: begin
        if (cnt_q == 5'(LEN_NIJ)) begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_EXEC: begin
        if (cnt_q == 5'(EXEC_CYC - 1)) begin
          cnt_d = '0;
          if (ic_q == nic_q - 4'd1) begin
            state_d = S_DRAIN;
          end else begin
            ic_d    = ic_q + 4'd1;
            state_d = S_WFETCH;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == 5'(DRAIN_CYC - 1)) begin
          state_d = S_OUTWR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_OUTWR: begin
        if (w_q == 4'(LEN_ONIJ)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A row read this cycle is written to pmem in the following cycle (rd_q).
    if (state_d == S_OUTWR) begin
      r_base = (state_q == S_OUTWR) ? r_q : 4'd0;
      w_base = (state_q == S_OUTWR) ? w_q : 4'd0;
      rd_d   = (r_base < 4'(LEN_ONIJ)) && ofifo_valid;
      wr     = rd_q;
      r_d    = r_base + {3'd0, rd_d};
      w_d    = w_base + {3'd0, wr};
    end

    inst_d = IDLE_WORD;
    unique case (state_d)
      S_WFETCH: begin
        if (cnt_d < 5'(LEN_KIJ)) begin
          inst_d.cen_xmem = 1'b0;
          inst_d.a_xmem   = W_BASE + 11'(cnt_d);
        end
        inst_d.ififo_wr = (cnt_d != 5'd0);
      end
      S_AFETCH: begin
        if (cnt_d < 5'(LEN_NIJ)) begin
          inst_d.cen_xmem = 1'b0;
          inst_d.a_xmem   = A_BASE + 11'(cnt_d);
        end
        inst_d.l0_wr = (cnt_d != 5'd0);
      end
      S_EXEC: begin
        inst_d.l0_rd    = (cnt_d < 5'(LEN_NIJ));
        inst_d.ififo_rd = (cnt_d < 5'(LEN_NIJ));
        inst_d.execute  = (cnt_d < 5'(LEN_NIJ - 2));
      end
      S_DRAIN: inst_d.output_en = 1'b1;
      S_OUTWR: begin
        inst_d.ofifo_rd = rd_d;
        if (wr) begin
          inst_d.cen_pmem = 1'b0;
          inst_d.wen_pmem = 1'b0;
          inst_d.a_pmem   = P_BASE + 11'(w_base);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ic_q    <= '0;
      nic_q   <= '0;
      r_q     <= '0;
      w_q     <= '0;
      rd_q    <= 1'b0;
      inst_q  <= IDLE_WORD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ic_q    <= ic_d;
      nic_q   <= nic_d;
      r_q     <= r_d;
      w_q     <= w_d;
      rd_q    <= rd_d;
      inst_q  <= inst_d;
      busy_q  <= !(state_d inside {S_IDLE, S_DONE});
      done_q  <= (state_d == S_DONE);
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_os_inst_sequencer.sv
// Bench for os_inst_sequencer: per-cycle trace model built from the job rules, plus table of job totals.
module tb_os_inst_sequencer;
  localparam logic [10:0] W_BASE = 11'h400;
  localparam logic [10:0] A_BASE = 11'h000;
  localparam logic [10:0] P_BASE = 11'h000;

  logic        clk = 1'b0;
  logic        reset, start, ofifo_valid;
  logic [3:0]  num_ic;
  logic [35:0] inst;
  logic        busy, done;

  os_inst_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .num_ic(num_ic),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [35:0] w; logic b; logic d; } cyc_t;
  typedef struct { int nic; int vmode; bit extra; int busy_n; int ifwr; int l0wr; int ex; int oe; int pw; int xr; } vec_t;

  cyc_t expq[$];
  bit   vpat [0:2047];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [35:0] mk(input bit oe, input bit pw, input int pa, input bit xr, input int xa,
                                     input bit ofrd, input bit ifwr, input bit ifrd, input bit l0rd,
                                     input bit l0wr, input bit ex);
    logic [35:0] v;
    v        = '0;
    v[35]    = oe;
    v[34]    = 1'b1;
    v[32]    = !pw;
    v[31]    = !pw;
    v[30:20] = pw ? 11'(pa) : 11'd0;
    v[19]    = !xr;
    v[18]    = 1'b1;
    v[17:7]  = xr ? 11'(xa) : 11'd0;
    v[6]     = ofrd;
    v[5]     = ifwr;
    v[4]     = ifrd;
    v[3]     = l0rd;
    v[2]     = l0wr;
    v[1]     = ex;
    return v;
  endfunction

  function automatic logic [35:0] idle_w();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void push(input logic [35:0] w, input bit b, input bit d);
    cyc_t e;
    e.w = w; e.b = b; e.d = d;
    expq.push_back(e);
  endfunction

  // Expected output, cycle by cycle, for a whole job; entry i is output cycle i+1 after the start edge.
  function automatic void build(input int nic);
    int r, w;
    bit pend, rd;
    expq.delete();
    if (nic == 0) begin
      push(idle_w(), 0, 1);
      return;
    end
    for (int ic = 0; ic < nic; ic++) begin
      for (int k = 0; k <= 9; k++) push(mk(0, 0, 0, k < 9, int'(W_BASE) + k, 0, k >= 1, 0, 0, 0, 0), 1, 0);
      for (int k = 0; k <= 9; k++) push(mk(0, 0, 0, k < 9, int'(A_BASE) + k, 0, 0, 0, 0, k >= 1, 0), 1, 0);
      for (int e = 0; e < 21; e++) push(mk(0, 0, 0, 0, 0, 0, 0, e < 9, e < 9, 0, e < 7), 1, 0);
    end
    for (int d = 0; d < 10; d++) push(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0);
    r = 0; w = 0; pend = 0;
    while (w < 8) begin
      rd = (r < 8) && vpat[expq.size() + 1];
      push(mk(0, pend, int'(P_BASE) + w, 0, 0, rd, 0, 0, 0, 0, 0), 1, 0);
      if (pend) w++;
      if (rd) r++;
      pend = rd;
    end
    push(idle_w(), 0, 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // vmode: 0 = ofifo_valid always high, 1 = random, 2 = 4-cycle gap after the third row read
  task automatic run_job(input int nic, input int vmode, input bit extra,
                         output int busy_n, output int ifwr_n, output int l0wr_n, output int ex_n,
                         output int oe_n, output int pw_n, output int xr_n);
    int   c0, total;
    cyc_t e;
    c0 = 41 * nic + 11;
    for (int c = 0; c < 2048; c++) vpat[c] = (vmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (vmode == 2) for (int c = c0 + 3; c <= c0 + 6; c++) vpat[c] = 1'b0;
    build(nic);
    total = expq.size();
    busy_n = 0; ifwr_n = 0; l0wr_n = 0; ex_n = 0; oe_n = 0; pw_n = 0; xr_n = 0;
    start = 1'b1; num_ic = 4'(nic); ofifo_valid = vpat[0];
    for (int c = 1; c <= total + 2; c++) begin
      @(posedge clk); #1;
      start = (extra && c == 5);
      if (extra && c == 5) num_ic = 4'($urandom_range(1, 15));
      ofifo_valid = vpat[c + 1];
      if (c <= total) e = expq[c - 1];
      else begin e.w = idle_w(); e.b = 0; e.d = 0; end
      chk($sformatf("nic%0d cyc%0d {inst,busy,done}", nic, c), {26'd0, inst, busy, done}, {26'd0, e.w, e.b, e.d});
      if (busy) busy_n++;
      if (inst[5]) ifwr_n++;
      if (inst[2]) l0wr_n++;
      if (inst[1]) ex_n++;
      if (inst[35]) oe_n++;
      if (!inst[19]) xr_n++;
      if (!inst[32] && !inst[31]) begin
        chk($sformatf("nic%0d pmem addr row%0d", nic, pw_n), {53'd0, inst[30:20]}, {53'd0, 11'(int'(P_BASE) + pw_n)});
        pw_n++;
      end
    end
  endtask

  task automatic check_totals(input vec_t v);
    int b, ifw, l0w, ex, oe, pw, xr;
    run_job(v.nic, v.vmode, v.extra, b, ifw, l0w, ex, oe, pw, xr);
    chk($sformatf("nic%0d busy cycles", v.nic), 64'(b), 64'(v.busy_n));
    chk($sformatf("nic%0d ififo_wr count", v.nic), 64'(ifw), 64'(v.ifwr));
    chk($sformatf("nic%0d l0_wr count", v.nic), 64'(l0w), 64'(v.l0wr));
    chk($sformatf("nic%0d execute count", v.nic), 64'(ex), 64'(v.ex));
    chk($sformatf("nic%0d output_en count", v.nic), 64'(oe), 64'(v.oe));
    chk($sformatf("nic%0d pmem writes", v.nic), 64'(pw), 64'(v.pw));
    chk($sformatf("nic%0d xmem reads", v.nic), 64'(xr), 64'(v.xr));
  endtask

  initial begin
    vec_t tbl[6];
    int   b, ifw, l0w, ex, oe, pw, xr;
    tbl[0] = '{1,  0, 0, 60,  9,   9,   7,   10, 8, 18};
    tbl[1] = '{3,  0, 0, 142, 27,  27,  21,  10, 8, 54};
    tbl[2] = '{1,  2, 0, 64,  9,   9,   7,   10, 8, 18};
    tbl[3] = '{0,  0, 0, 0,   0,   0,   0,   0,  0, 0};
    tbl[4] = '{2,  0, 1, 101, 18,  18,  14,  10, 8, 36};
    tbl[5] = '{15, 0, 0, 634, 135, 135, 105, 10, 8, 270};

    reset = 1'b1; start = 1'b0; num_ic = 4'd0; ofifo_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("reset inst", {28'd0, inst}, {28'd0, idle_w()});
    chk("reset busy/done", {62'd0, busy, done}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post-reset inst", {28'd0, inst}, {28'd0, idle_w()});

    foreach (tbl[i]) check_totals(tbl[i]);

    // Reset during EXEC cycle 5 of channel 1 of a two-channel job.
    for (int c = 0; c < 2048; c++) vpat[c] = 1'b1;
    build(2);
    start = 1'b1; num_ic = 4'd2;
    for (int c = 1; c <= 67; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("pre-reset exec word", {26'd0, inst, busy, done}, {26'd0, expq[66].w, expq[66].b, expq[66].d});
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid-job reset inst", {28'd0, inst}, {28'd0, idle_w()});
    chk("mid-job reset busy/done", {62'd0, busy, done}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("after reset idle", {26'd0, inst, busy, done}, {26'd0, idle_w(), 2'b00});
    check_totals(tbl[0]);

    for (int i = 0; i < 6; i++) begin
      int nic;
      nic = $urandom_range(1, 4);
      run_job(nic, 1, 1'($urandom_range(0, 1)), b, ifw, l0w, ex, oe, pw, xr);
      chk($sformatf("random job %0d pmem writes", i), 64'(pw), 64'd8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
